// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake sequencer and its button/datapath surroundings.
// Master drives buttons and datapath status; slave is the sequencer itself.
interface snake_game_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic [5:0] len;
  logic       died;
  logic       step;
  logic [1:0] direction;
  logic       game_rst;
  logic [1:0] state;
  logic [2:0] level;
  logic [5:0] score;

  // No valid/ready handshake here: buttons are levels, died/step are 1-cycle pulses.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_start, len, died,
    input  step, direction, game_rst, state, level, score
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_start, len, died,
    output step, direction, game_rst, state, level, score
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game state, step pulse timing scaled by length,
// and direction latching with the no-reversal rule.
module snake_game_ctrl #(
  parameter logic [23:0] BASE_PERIOD   = 24'd6250000,
  parameter logic [23:0] PERIOD_DEC    = 24'd625000,
  parameter logic [23:0] MIN_PERIOD    = 24'd1250000,
  parameter int unsigned LEN_PER_LEVEL = 3,
  parameter logic [5:0]  WIN_LEN       = 6'd36
) (
  input  logic               clk,
  input  logic               rst,
  snake_game_ctrl_if.slave   ctrl_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_t      r_state;
  logic [4:0]  r_btn_q;
  logic [23:0] r_counter;
  logic        r_step;
  logic [1:0]  r_direction;
  logic [1:0]  r_pending;
  logic        r_game_rst;
  logic [2:0]  r_level;
  logic [5:0]  r_score;

  logic [4:0]  w_btn;
  logic [4:0]  w_press;
  logic        w_start_press;
  logic        w_req_valid;
  logic [1:0]  w_req_dir;
  logic        w_req_opposite;
  logic [5:0]  w_len_eff;
  logic [5:0]  w_quot;
  logic [2:0]  w_level;
  logic [27:0] w_dec;
  logic [23:0] w_period;
  logic        w_due;
  logic [5:0]  w_score;

  state_t      w_next_state;
  logic        w_step_d;
  logic [23:0] w_counter_d;
  logic [1:0]  w_dir_d;
  logic [1:0]  w_pend_d;

  // Bit order: {start, up, down, left, right}
  assign w_btn         = {ctrl_bus.btn_start, ctrl_bus.btn_up, ctrl_bus.btn_down,
                          ctrl_bus.btn_left, ctrl_bus.btn_right};
  assign w_press       = w_btn & ~r_btn_q;
  assign w_start_press = w_press[4];

  // Only the highest-priority pressed direction is considered.
  always_comb begin
    w_req_valid = 1'b1;
    w_req_dir   = DIR_UP;
    if (w_press[3])      w_req_dir = DIR_UP;
    else if (w_press[2]) w_req_dir = DIR_DOWN;
    else if (w_press[1]) w_req_dir = DIR_LEFT;
    else if (w_press[0]) w_req_dir = DIR_RIGHT;
    else                 w_req_valid = 1'b0;
  end

  // Opposites share the axis bit and differ in the sense bit.
  assign w_req_opposite = (w_req_dir[1] == r_direction[1]) &&
                          (w_req_dir[0] != r_direction[0]);

  always_comb begin
    w_len_eff = (ctrl_bus.len < 6'd2) ? 6'd2 : ctrl_bus.len;
    w_quot    = (w_len_eff - 6'd2) / 6'(LEN_PER_LEVEL);
    w_level   = (w_quot > 6'd7) ? 3'd7 : w_quot[2:0];
    w_score   = (ctrl_bus.len >= 6'd2) ? (ctrl_bus.len - 6'd2) : 6'd0;
  end

  // Wide arithmetic so the subtraction can never wrap below the floor.
  always_comb begin
    w_dec = 28'(r_level) * 28'(PERIOD_DEC);
    if (w_dec + 28'(MIN_PERIOD) >= 28'(BASE_PERIOD)) w_period = MIN_PERIOD;
    else                                              w_period = BASE_PERIOD - w_dec[23:0];
  end

  // ">=" rather than "==" so a shortened period fires on the next cycle.
  assign w_due = (r_counter >= (w_period - 24'd1));

  always_comb begin
    w_next_state = r_state;
    w_step_d     = 1'b0;
    w_counter_d  = r_counter;
    w_dir_d      = r_direction;
    w_pend_d     = r_pending;
    case (r_state)
      S_IDLE: begin
        w_counter_d = 24'd0;
        if (w_start_press) w_next_state = S_PLAY;
      end
      S_PLAY: begin
        if (w_req_valid && !w_req_opposite) w_pend_d = w_req_dir;
        if (ctrl_bus.died) begin
          w_next_state = S_OVER;
          w_counter_d  = 24'd0;
        end else if (ctrl_bus.len >= WIN_LEN) begin
          w_next_state = S_WIN;
          w_counter_d  = 24'd0;
        end else if (w_due) begin
          w_counter_d = 24'd0;
          w_step_d    = 1'b1;
          w_dir_d     = r_pending;
        end else begin
          w_counter_d = r_counter + 24'd1;
        end
      end
      S_OVER, S_WIN: begin
        w_counter_d = 24'd0;
        if (w_start_press) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_next_state == S_IDLE) begin
      w_dir_d  = DIR_RIGHT;
      w_pend_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_btn_q     <= 5'd0;
      r_counter   <= 24'd0;
      r_step      <= 1'b0;
      r_direction <= DIR_RIGHT;
      r_pending   <= DIR_RIGHT;
      r_game_rst  <= 1'b1;
      r_level     <= 3'd0;
      r_score     <= 6'd0;
    end else begin
      r_state     <= w_next_state;
      r_btn_q     <= w_btn;
      r_counter   <= w_counter_d;
      r_step      <= w_step_d;
      r_direction <= w_dir_d;
      r_pending   <= w_pend_d;
      r_game_rst  <= (w_next_state == S_IDLE);
      r_level     <= w_level;
      r_score     <= (w_next_state == S_IDLE) ? 6'd0 : w_score;
    end
  end

  assign ctrl_bus.step      = r_step;
  assign ctrl_bus.direction = r_direction;
  assign ctrl_bus.game_rst  = r_game_rst;
  assign ctrl_bus.state     = r_state;
  assign ctrl_bus.level     = r_level;
  assign ctrl_bus.score     = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios followed by random play,
// every cycle compared against a cycle-level reference model of the game rules.
module tb_snake_game_ctrl;

  localparam int BASE = 10;
  localparam int DEC  = 2;
  localparam int MINP = 4;
  localparam int LPL  = 3;
  localparam int WINL = 36;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  snake_game_ctrl_if u_if ();

  snake_game_ctrl #(
    .BASE_PERIOD   (24'(BASE)),
    .PERIOD_DEC    (24'(DEC)),
    .MIN_PERIOD    (24'(MINP)),
    .LEN_PER_LEVEL (LPL),
    .WIN_LEN       (6'(WINL))
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl_bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, plain integers.
  int m_state, m_step, m_dir, m_pend, m_cnt, m_level, m_score, m_grst;
  int q_up, q_down, q_left, q_right, q_start;
  int opp [4] = '{1, 0, 3, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int p_up, p_down, p_left, p_right, p_start;
    int period, le, nlev, nstate, nstep, ndir, npend, req, len_i;
    len_i = int'(u_if.len);
    if (rst) begin
      m_state = 0; m_step = 0; m_dir = 3; m_pend = 3; m_cnt = 0;
      m_level = 0; m_score = 0; m_grst = 1;
      q_up = 0; q_down = 0; q_left = 0; q_right = 0; q_start = 0;
      return;
    end
    p_up    = (u_if.btn_up    && q_up    == 0) ? 1 : 0;
    p_down  = (u_if.btn_down  && q_down  == 0) ? 1 : 0;
    p_left  = (u_if.btn_left  && q_left  == 0) ? 1 : 0;
    p_right = (u_if.btn_right && q_right == 0) ? 1 : 0;
    p_start = (u_if.btn_start && q_start == 0) ? 1 : 0;
    q_up = int'(u_if.btn_up); q_down = int'(u_if.btn_down); q_left = int'(u_if.btn_left);
    q_right = int'(u_if.btn_right); q_start = int'(u_if.btn_start);

    period = BASE - m_level * DEC;
    if (period < MINP) period = MINP;
    le   = (len_i < 2) ? 2 : len_i;
    nlev = (le - 2) / LPL;
    if (nlev > 7) nlev = 7;

    nstate = m_state; nstep = 0; ndir = m_dir; npend = m_pend;
    case (m_state)
      0: begin
        m_cnt = 0;
        if (p_start == 1) nstate = 1;
      end
      1: begin
        req = -1;
        if (p_up == 1) req = 0;
        else if (p_down == 1) req = 1;
        else if (p_left == 1) req = 2;
        else if (p_right == 1) req = 3;
        if (req >= 0 && req != opp[m_dir]) npend = req;
        if (u_if.died) nstate = 2;
        else if (len_i >= WINL) nstate = 3;
        else if (m_cnt >= period - 1) begin
          nstep = 1; ndir = m_pend; m_cnt = 0;
        end else m_cnt = m_cnt + 1;
      end
      default: if (p_start == 1) nstate = 0;
    endcase
    if (nstate == 0) begin ndir = 3; npend = 3; m_cnt = 0; end
    m_state = nstate; m_step = nstep; m_dir = ndir; m_pend = npend;
    m_grst  = (nstate == 0) ? 1 : 0;
    m_score = (nstate == 0) ? 0 : ((len_i >= 2) ? len_i - 2 : 0);
    m_level = nlev;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("step",      32'(u_if.step),      32'(m_step));
    check("direction", 32'(u_if.direction), 32'(m_dir));
    check("state",     32'(u_if.state),     32'(m_state));
    check("game_rst",  32'(u_if.game_rst),  32'(m_grst));
    check("level",     32'(u_if.level),     32'(m_level));
    check("score",     32'(u_if.score),     32'(m_score));
  endtask

  task automatic wait_step(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cycle();
      n++;
      if (u_if.step === 1'b1) break;
    end
  endtask

  task automatic press_start();
    u_if.btn_start = 1'b1;
    cycle();
    u_if.btn_start = 1'b0;
  endtask

  initial begin
    int n;
    int cnt_steps;
    n_cmp = 0;
    n_err = 0;
    u_if.btn_up = 1'b0; u_if.btn_down = 1'b0; u_if.btn_left = 1'b0;
    u_if.btn_right = 1'b0; u_if.btn_start = 1'b0;
    u_if.len = 6'd2; u_if.died = 1'b0;
    rst = 1'b1;

    // Reset
    cycle(); cycle();
    check("rst_state", 32'(u_if.state), 32'd0);
    check("rst_game_rst", 32'(u_if.game_rst), 32'd1);
    check("rst_direction", 32'(u_if.direction), 32'd3);
    check("rst_step", 32'(u_if.step), 32'd0);
    check("rst_score_level", {26'd0, u_if.score} + {29'd0, u_if.level}, 32'd0);
    rst = 1'b0;
    cycle();

    // Start and base step period
    press_start();
    check("play_state", 32'(u_if.state), 32'd1);
    check("play_game_rst", 32'(u_if.game_rst), 32'd0);
    wait_step(40, n);
    check("first_step_latency", 32'(n), 32'd10);
    check("first_step_dir", 32'(u_if.direction), 32'd3);
    wait_step(40, n);
    check("step_interval_base", 32'(n), 32'd10);

    // Reversal rejected, up accepted, priority up over right
    u_if.btn_left = 1'b1; cycle(); u_if.btn_left = 1'b0;
    wait_step(40, n);
    check("reverse_step_seen", 32'(u_if.step), 32'd1);
    check("reverse_rejected", 32'(u_if.direction), 32'd3);
    u_if.btn_up = 1'b1; cycle(); u_if.btn_up = 1'b0;
    wait_step(40, n);
    check("up_accepted", 32'(u_if.direction), 32'd0);
    u_if.btn_left = 1'b1; cycle(); u_if.btn_left = 1'b0; cycle();
    u_if.btn_up = 1'b1; u_if.btn_right = 1'b1; cycle();
    u_if.btn_up = 1'b0; u_if.btn_right = 1'b0;
    wait_step(40, n);
    check("priority_up", 32'(u_if.direction), 32'd0);

    // Death, freeze, restart
    cycle();
    u_if.died = 1'b1; cycle(); u_if.died = 1'b0;
    check("died_over", 32'(u_if.state), 32'd2);
    check("over_game_rst", 32'(u_if.game_rst), 32'd0);
    cnt_steps = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (u_if.step === 1'b1) cnt_steps++;
    end
    check("over_no_step", 32'(cnt_steps), 32'd0);
    press_start();
    check("over_to_idle", 32'(u_if.state), 32'd0);
    check("idle_game_rst", 32'(u_if.game_rst), 32'd1);
    cycle();
    press_start();
    check("idle_to_play", 32'(u_if.state), 32'd1);

    // Speed levels
    u_if.len = 6'd5;
    cycle();
    check("level_len5", 32'(u_if.level), 32'd1);
    wait_step(40, n);
    wait_step(40, n);
    check("interval_len5", 32'(n), 32'd8);
    u_if.len = 6'd14;
    cycle();
    check("level_len14", 32'(u_if.level), 32'd4);
    wait_step(40, n);
    wait_step(40, n);
    check("interval_len14", 32'(n), 32'd4);
    u_if.len = 6'd40;
    cycle();
    check("level_len40", 32'(u_if.level), 32'd7);
    check("len40_win", 32'(u_if.state), 32'd3);
    check("len40_score", 32'(u_if.score), 32'd38);

    // Win versus death priority
    press_start(); cycle();
    u_if.len = 6'd2;
    press_start(); cycle();
    u_if.len = 6'd36; u_if.died = 1'b1; cycle();
    u_if.died = 1'b0;
    check("win_and_died_over", 32'(u_if.state), 32'd2);
    u_if.len = 6'd2;
    press_start(); cycle();
    press_start(); cycle();
    u_if.len = 6'd36; cycle();
    check("win_state", 32'(u_if.state), 32'd3);
    check("win_score", 32'(u_if.score), 32'd34);
    u_if.len = 6'd2;

    // Random play
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 3) == 0) u_if.btn_up    = ~u_if.btn_up;
      if ($urandom_range(0, 3) == 0) u_if.btn_down  = ~u_if.btn_down;
      if ($urandom_range(0, 3) == 0) u_if.btn_left  = ~u_if.btn_left;
      if ($urandom_range(0, 3) == 0) u_if.btn_right = ~u_if.btn_right;
      u_if.btn_start = ($urandom_range(0, 39) == 0);
      u_if.died      = ($urandom_range(0, 299) == 0);
      rst            = ($urandom_range(0, 999) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 3)       u_if.len = 6'($urandom_range(0, 63));
      else if (r < 15) u_if.len = 6'($urandom_range(0, 34));
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
